// File: rtl/crc24_ble.sv
// -----------------------------------------------------------------------------
// crc24_ble
//
// Bit-serial BLE CRC-24 generator that sits directly in front of the whitener.
// PDU bits pass through with one cycle of latency while the CRC accumulates.
// After the last PDU bit, the 24 CRC bits follow back-to-back. This gives the
// whitener one contiguous valid stream that covers both the PDU and the CRC.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   enable     0 = idle with the LFSR held at crc_init, 1 = packet in progress
//   crc_init   LFSR preset; crc_init[i] loads LFSR position i
//   valid_in   data_in carries a PDU bit this cycle
//   data_in    PDU bit in air order (LSB of each octet first)
//   last_in    end of PDU; with valid_in=0 the PDU ends without a bit
//   valid_out  data_out is valid (drives the whitener's valid_in)
//   data_out   PDU bit or CRC bit
//   finished   CRC fully emitted
// -----------------------------------------------------------------------------
module crc24_ble (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] crc_init,
    input  logic        valid_in,
    input  logic        data_in,
    input  logic        last_in,
    output logic        valid_out,
    output logic        data_out,
    output logic        finished
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        valid_out_q, valid_out_d;
    logic        data_out_q, data_out_d;
    logic        finished_q, finished_d;

    logic        fb;
    logic [23:0] p_step;
    logic [23:0] p_shift;

    // One LFSR step for the polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1.
    // The feedback is XORed into positions 0, 1, 3, 4, 6, 9 and 10.
    always_comb begin
        fb      = data_in ^ p_q[23];
        p_step  = {p_q[22:10],
                   p_q[9] ^ fb,
                   p_q[8] ^ fb,
                   p_q[7],
                   p_q[6],
                   p_q[5] ^ fb,
                   p_q[4],
                   p_q[3] ^ fb,
                   p_q[2] ^ fb,
                   p_q[1],
                   p_q[0] ^ fb,
                   fb};
        p_shift = {p_q[22:0], 1'b0};
    end

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        valid_out_d = 1'b0;
        data_out_d  = 1'b0;
        finished_d  = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            p_d     = crc_init;
            cnt_d   = 5'd0;
        end else begin
            unique case (state_q)
                // IDLE behaves exactly like DATA in the first enabled cycle.
                IDLE, DATA: begin
                    state_d = DATA;
                    if (valid_in) begin
                        valid_out_d = 1'b1;
                        data_out_d  = data_in;
                        p_d         = p_step;
                    end
                    if (last_in) begin
                        state_d = CRC;
                        cnt_d   = 5'd0;
                        // If the PDU ends without a bit, no data bit occupies
                        // the next output slot. The first CRC bit is emitted
                        // immediately, so the CRC starts one cycle after last_in.
                        if (!valid_in) begin
                            valid_out_d = 1'b1;
                            data_out_d  = p_q[23];
                            p_d         = p_shift;
                            cnt_d       = 5'd1;
                        end
                    end
                end
                CRC: begin
                    valid_out_d = 1'b1;
                    data_out_d  = p_q[23];
                    p_d         = p_shift;
                    if (cnt_q == 5'd23) begin
                        state_d = DONE;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    finished_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Out of reset, finished reads 1 to mean "nothing pending".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            p_q         <= 24'h000000;
            cnt_q       <= 5'd0;
            valid_out_q <= 1'b0;
            data_out_q  <= 1'b0;
            finished_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            finished_q  <= finished_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_crc24_ble.sv
// -----------------------------------------------------------------------------
// tb_crc24_ble
//
// Directed bench for crc24_ble. It drives PDUs as slot sequences, where each
// slot is either a bit or a gap. It records the output stream, then checks:
// - the delayed data and valid pattern,
// - the 24-cycle CRC run,
// - the finished flag.
// Expected CRC values are either hand-derived constants or come from a
// Galois-form CRC model.
// -----------------------------------------------------------------------------
module tb_crc24_ble;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic [23:0] crc_init = 24'h000000;
    logic        valid_in = 1'b0;
    logic        data_in  = 1'b0;
    logic        last_in  = 1'b0;
    logic        valid_out;
    logic        data_out;
    logic        finished;

    int check_count = 0;
    int error_count = 0;

    logic slot_v[$];
    logic slot_d[$];

    crc24_ble dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .crc_init  (crc_init),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC using the Galois mask form of the BLE polynomial.
    function automatic logic [23:0] crcModel(input logic [23:0] init, input int n,
                                             input logic [63:0] bits);
        logic [23:0] p;
        logic        fb;
        p = init;
        for (int i = 0; i < n; i++) begin
            fb = bits[i] ^ p[23];
            p  = {p[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
        end
        return p;
    endfunction

    // Builds the slot list; gap_before[i] inserts one idle slot ahead of bit i.
    task automatic buildPdu(input int n, input logic [63:0] bits, input logic [63:0] gap_before);
        slot_v.delete();
        slot_d.delete();
        for (int i = 0; i < n; i++) begin
            if (gap_before[i]) begin
                slot_v.push_back(1'b0);
                slot_d.push_back(1'b0);
            end
            slot_v.push_back(1'b1);
            slot_d.push_back(bits[i]);
        end
    endtask

    // Runs the current slot list as one packet and checks the whole output stream.
    task automatic applyStimulus(input string tag, input logic [23:0] init,
                                 input logic [23:0] exp_crc);
        int          n;
        int          crc_start;
        logic        rec_v[$];
        logic        rec_d[$];
        logic        rec_f[$];
        logic [63:0] got_v, exp_v, got_d, exp_d;
        logic [23:0] crc_bits, crc_valid;
        logic        busy_fin;

        n = slot_v.size();
        enable   = 1'b0;
        crc_init = init;
        valid_in = 1'b0;
        data_in  = 1'b0;
        last_in  = 1'b0;
        tick();
        enable = 1'b1;
        for (int k = 0; k < n + 26; k++) begin
            if (k < n) begin
                valid_in = slot_v[k];
                data_in  = slot_d[k];
                last_in  = (k == n - 1);
            end else begin
                valid_in = 1'b0;
                data_in  = 1'b0;
                last_in  = 1'b0;
            end
            tick();
            rec_v.push_back(valid_out);
            rec_d.push_back(data_out);
            rec_f.push_back(finished);
        end
        enable = 1'b0;

        crc_start = slot_v[n-1] ? n : n - 1;
        got_v = '0; exp_v = '0; got_d = '0; exp_d = '0;
        busy_fin = 1'b0;
        for (int k = 0; k < crc_start; k++) begin
            got_v[k] = rec_v[k];
            exp_v[k] = slot_v[k];
            got_d[k] = rec_d[k];
            exp_d[k] = slot_v[k] & slot_d[k];
            busy_fin = busy_fin | rec_f[k];
        end
        if (crc_start > 0) begin
            checkOutput({tag, " data valid"}, got_v, exp_v);
            checkOutput({tag, " data bits"}, got_d, exp_d);
        end

        crc_bits  = '0;
        crc_valid = '0;
        for (int k = 0; k < 24; k++) begin
            crc_bits     = {crc_bits[22:0], rec_d[crc_start+k]};
            crc_valid[k] = rec_v[crc_start+k];
            busy_fin     = busy_fin | rec_f[crc_start+k];
        end
        checkOutput({tag, " crc valid run"}, 64'(crc_valid), 64'hFFFFFF);
        checkOutput({tag, " finished low while busy"}, 64'(busy_fin), 64'h0);
        checkOutput({tag, " crc value"}, 64'(crc_bits), 64'(exp_crc));
        checkOutput({tag, " valid after crc"}, 64'(rec_v[crc_start+24]), 64'h0);
        checkOutput({tag, " finished"}, 64'(rec_f[crc_start+24]), 64'h1);
    endtask

    initial begin
        // Reset state, then release with enable low.
        #3 reset = 1'b0;
        #1;
        checkOutput("reset valid_out", 64'(valid_out), 64'h0);
        checkOutput("reset data_out", 64'(data_out), 64'h0);
        checkOutput("reset finished", 64'(finished), 64'h1);
        #4 reset = 1'b1;
        #1;
        checkOutput("released finished before clock", 64'(finished), 64'h1);
        tick();
        checkOutput("idle finished", 64'(finished), 64'h0);
        checkOutput("idle valid_out", 64'(valid_out), 64'h0);

        // Zero-length PDU with the advertising preset: alternating 0,1,... CRC.
        slot_v.delete();
        slot_d.delete();
        slot_v.push_back(1'b0);
        slot_d.push_back(1'b0);
        applyStimulus("zero-length", 24'h555555, 24'h555555);

        // A single 1 bit from a zero preset yields 0x00065B.
        buildPdu(1, 64'h1, 64'h0);
        applyStimulus("single bit", 24'h000000, 24'h00065B);

        // Multi-byte PDU, both gap-free and with gaps.
        buildPdu(24, 64'h0F3CA5, 64'h0);
        applyStimulus("multi plain", 24'h555555, crcModel(24'h555555, 24, 64'h0F3CA5));
        buildPdu(24, 64'h0F3CA5, 64'h81_080A);
        applyStimulus("multi gapped", 24'h555555, crcModel(24'h555555, 24, 64'h0F3CA5));
        buildPdu(16, 64'hBEEF, 64'h8001);
        applyStimulus("beef gapped", 24'h123456, crcModel(24'h123456, 16, 64'hBEEF));

        // Abort after 10 CRC bits, then restart.
        buildPdu(3, 64'h5, 64'h0);
        enable   = 1'b0;
        crc_init = 24'h555555;
        tick();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid_in = slot_v[k];
            data_in  = slot_d[k];
            last_in  = (k == 2);
            tick();
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
        last_in  = 1'b0;
        repeat (10) tick();
        checkOutput("abort pre valid_out", 64'(valid_out), 64'h1);
        enable = 1'b0;
        tick();
        checkOutput("abort valid_out", 64'(valid_out), 64'h0);
        checkOutput("abort finished", 64'(finished), 64'h0);
        applyStimulus("restart", 24'h555555, crcModel(24'h555555, 3, 64'h5));

        // Asynchronous reset in the middle of the CRC phase.
        buildPdu(2, 64'h3, 64'h0);
        enable   = 1'b0;
        crc_init = 24'h000000;
        tick();
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid_in = slot_v[k];
            data_in  = slot_d[k];
            last_in  = (k == 1);
            tick();
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
        last_in  = 1'b0;
        repeat (5) tick();
        checkOutput("pre-reset valid_out", 64'(valid_out), 64'h1);
        checkOutput("pre-reset finished", 64'(finished), 64'h0);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid-crc reset valid_out", 64'(valid_out), 64'h0);
        checkOutput("mid-crc reset data_out", 64'(data_out), 64'h0);
        checkOutput("mid-crc reset finished", 64'(finished), 64'h1);
        enable = 1'b0;
        #10 reset = 1'b1;
        tick();
        checkOutput("post-reset idle finished", 64'(finished), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
